// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage of the Gumnut core. Owns the program counter and
// the instruction register. Runs exactly one instruction-memory bus cycle
// each time the control unit enters its fetch state. Presents the raw
// opcode and function fields for the control unit to decode.
//
// Ports:
//   clk, rst        core clock and asynchronous active-high reset
//   fetch_en_i      control unit is in its fetch state
//   inst_adr_o      instruction address (always equals pc_o)
//   inst_cyc_o      bus cycle active
//   inst_stb_o      bus strobe (identical to inst_cyc_o)
//   inst_ack_i      instruction memory acknowledge
//   inst_dat_i      instruction read data, sampled only on ack in BUS
//   pc_load_i       load the PC from pc_target_i
//   pc_target_i     branch/jump/return target
//   pc_o, pc_inc_o  current PC and PC+1 (wraps modulo 2^PC_W)
//   ir_o            instruction register
//   op_o, func_o    opcode ir_o[17:11] and function ir_o[2:0] fields
//   ir_valid_o      one-cycle pulse when IR first holds a new word
//   fetch_err_o     one-cycle pulse on bus timeout
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a bus cycle that has
// not been acknowledged within TIMEOUT cycles. Without it the bus cycle
// waits forever and fetch_err_o is tied low.
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int              PC_W     = 12,
  parameter int              IR_W     = 18,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en_i,
  output logic [PC_W-1:0] inst_adr_o,
  output logic            inst_cyc_o,
  output logic            inst_stb_o,
  input  logic            inst_ack_i,
  input  logic [IR_W-1:0] inst_dat_i,
  input  logic            pc_load_i,
  input  logic [PC_W-1:0] pc_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_inc_o,
  output logic [IR_W-1:0] ir_o,
  output logic [6:0]      op_o,
  output logic [2:0]      func_o,
  output logic            ir_valid_o,
  output logic            fetch_err_o
);

  typedef enum logic [1:0] {IDLE, BUS, ARM} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            cyc_q, cyc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            fetch_err_q, fetch_err_d;
  // A PC load arriving mid bus cycle is parked here so the address stays
  // stable until the cycle ends.
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Next-state logic for the fetch handshake and the PC/IR registers.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = 1'b0;
    fetch_err_d = 1'b0;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pc_load_i) pc_d = pc_target_i;
        if (fetch_en_i) begin
          state_d = BUS;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        if (inst_ack_i) begin
          // A coincident load wins over the increment; IR is still captured.
          ir_d       = inst_dat_i;
          ir_valid_d = 1'b1;
          state_d    = ARM;
          pend_d     = 1'b0;
          if (pc_load_i)   pc_d = pc_target_i;
          else if (pend_q) pc_d = pend_tgt_q;
          else             pc_d = pc_q + PC_W'(1);
        end else begin
          if (pc_load_i) begin
            pend_d     = 1'b1;
            pend_tgt_d = pc_target_i;
          end
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abort: no increment, no IR capture; a parked load still lands.
            state_d     = IDLE;
            fetch_err_d = 1'b1;
            pend_d      = 1'b0;
            if (pc_load_i)   pc_d = pc_target_i;
            else if (pend_q) pc_d = pend_tgt_q;
          end
`endif
        end
      end
      ARM: begin
        if (pc_load_i) pc_d = pc_target_i;
        if (!fetch_en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cyc_d = (state_d == BUS);
  end

  // State and registered outputs; reset drops the bus cycle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      cyc_q       <= 1'b0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cyc_q       <= cyc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter for the current bus cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign fetch_err_o = fetch_err_q;
`else
  assign fetch_err_o = 1'b0;
`endif

  assign inst_adr_o = pc_q;
  assign inst_cyc_o = cyc_q;
  assign inst_stb_o = cyc_q;
  assign pc_o       = pc_q;
  assign pc_inc_o   = pc_q + PC_W'(1);
  assign ir_o       = ir_q;
  assign op_o       = ir_q[IR_W-1 -: 7];
  assign func_o     = ir_q[2:0];
  assign ir_valid_o = ir_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit with RESET_PC = 0x010. Walks through
// reset, zero-wait and wait-state fetches, the one-fetch-per-enable rule,
// PC loads (coincident with ack and mid cycle), PC wrap, the timeout path
// (FETCH_TIMEOUT_EN) or indefinite wait (default), and reset mid cycle.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic [11:0] inst_adr_o;
  logic        inst_cyc_o;
  logic        inst_stb_o;
  logic        inst_ack_i;
  logic [17:0] inst_dat_i;
  logic        pc_load_i;
  logic [11:0] pc_target_i;
  logic [11:0] pc_o;
  logic [11:0] pc_inc_o;
  logic [17:0] ir_o;
  logic [6:0]  op_o;
  logic [2:0]  func_o;
  logic        ir_valid_o;
  logic        fetch_err_o;

  int checkCount = 0;
  int passCount  = 0;

  inst_fetch_unit #(
    .PC_W(12), .IR_W(18), .RESET_PC(12'h010), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en_i),
    .inst_adr_o(inst_adr_o), .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
    .inst_ack_i(inst_ack_i), .inst_dat_i(inst_dat_i),
    .pc_load_i(pc_load_i), .pc_target_i(pc_target_i),
    .pc_o(pc_o), .pc_inc_o(pc_inc_o), .ir_o(ir_o), .op_o(op_o),
    .func_o(func_o), .ir_valid_o(ir_valid_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive all inputs in one shot.
  task automatic applyStimulus(input logic en, input logic ack,
                               input logic [17:0] dat, input logic ld,
                               input logic [11:0] tgt);
    fetch_en_i  = en;
    inst_ack_i  = ack;
    inst_dat_i  = dat;
    pc_load_i   = ld;
    pc_target_i = tgt;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int errSeen;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    tick(); tick();

    // Reset state
    checkOutput("rst_pc", pc_o, 12'h010);
    checkOutput("rst_pc_inc", pc_inc_o, 12'h011);
    checkOutput("rst_adr", inst_adr_o, 12'h010);
    checkOutput("rst_cyc", inst_cyc_o, 1'b0);
    checkOutput("rst_stb", inst_stb_o, 1'b0);
    checkOutput("rst_ir", ir_o, 18'h0);
    checkOutput("rst_ir_valid", ir_valid_o, 1'b0);
    checkOutput("rst_fetch_err", fetch_err_o, 1'b0);
    rst = 1'b0;
    tick();

    // Zero-wait fetch of 0x3A5C7 from 0x010
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    checkOutput("zw_cyc", inst_cyc_o, 1'b1);
    checkOutput("zw_stb", inst_stb_o, 1'b1);
    checkOutput("zw_adr", inst_adr_o, 12'h010);
    applyStimulus(1'b1, 1'b1, 18'h3A5C7, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 18'h15555, 1'b0, 12'h0);
    checkOutput("zw_ir", ir_o, 18'h3A5C7);
    checkOutput("zw_op", op_o, 7'h74);
    checkOutput("zw_func", func_o, 3'h7);
    checkOutput("zw_pc", pc_o, 12'h011);
    checkOutput("zw_ir_valid", ir_valid_o, 1'b1);
    checkOutput("zw_cyc_after", inst_cyc_o, 1'b0);

    // fetch_en held high three cycles after ack: no second bus cycle
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (inst_cyc_o) n++;
      if (i == 0) checkOutput("zw_ir_valid_pulse", ir_valid_o, 1'b0);
    end
    checkOutput("arm_no_refetch", n, 0);
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();

    // Ack and data outside BUS are ignored
    applyStimulus(1'b0, 1'b1, 18'h2FFFF, 1'b0, 12'h0);
    tick();
    checkOutput("idle_ack_ignored_ir", ir_o, 18'h3A5C7);
    checkOutput("idle_ack_ignored_pc", pc_o, 12'h011);

    // Ack delayed three cycles: cyc/stb high exactly four cycles
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 18'h1F0F0, 1'b0, 12'h0);
      if (inst_cyc_o && inst_stb_o && inst_adr_o == 12'h011) n++;
      tick();
    end
    checkOutput("ws_ir_held", ir_o, 18'h3A5C7);
    if (inst_cyc_o && inst_stb_o && inst_adr_o == 12'h011) n++;
    applyStimulus(1'b1, 1'b1, 18'h0ABCD, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    if (inst_cyc_o) n++;
    checkOutput("ws_cyc_cycles", n, 4);
    checkOutput("ws_ir", ir_o, 18'h0ABCD);
    checkOutput("ws_pc", pc_o, 12'h012);
    checkOutput("ws_ir_valid", ir_valid_o, 1'b1);
    tick();

    // Load 0x123 coincident with ack
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 18'h12345, 1'b1, 12'h123);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("ld_ack_pc", pc_o, 12'h123);
    checkOutput("ld_ack_ir", ir_o, 18'h12345);
    tick();
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    checkOutput("ld_next_adr", inst_adr_o, 12'h123);
    applyStimulus(1'b1, 1'b1, 18'h00001, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("ld_next_pc", pc_o, 12'h124);
    tick();

    // Load mid bus cycle: address holds, target lands at ack
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b1, 12'h200);
    tick();
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("ld_mid_adr", inst_adr_o, 12'h124);
    checkOutput("ld_mid_cyc", inst_cyc_o, 1'b1);
    applyStimulus(1'b1, 1'b1, 18'h00F00, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("ld_mid_pc", pc_o, 12'h200);
    tick();

    // PC wrap at 0xFFF
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b1, 12'hFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("wrap_pc_pre", pc_o, 12'hFFF);
    checkOutput("wrap_pc_inc", pc_inc_o, 12'h000);
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    checkOutput("wrap_adr", inst_adr_o, 12'hFFF);
    applyStimulus(1'b1, 1'b1, 18'h00042, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("wrap_pc_post", pc_o, 12'h000);
    tick();

`ifdef FETCH_TIMEOUT_EN
    // No ack: abort after 16 BUS cycles, error pulse, retry
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    n = 0;
    while (inst_cyc_o && n < 40) begin
      n++;
      tick();
    end
    checkOutput("to_bus_cycles", n, 16);
    checkOutput("to_err", fetch_err_o, 1'b1);
    checkOutput("to_cyc_drop", inst_cyc_o, 1'b0);
    checkOutput("to_pc_held", pc_o, 12'h000);
    checkOutput("to_ir_held", ir_o, 18'h00042);
    tick();
    checkOutput("to_retry_cyc", inst_cyc_o, 1'b1);
    checkOutput("to_err_pulse", fetch_err_o, 1'b0);
`else
    // No ack: the bus cycle waits indefinitely, no error
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    n = 0;
    errSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_cyc_o) n++;
      if (fetch_err_o) errSeen++;
      tick();
    end
    checkOutput("wait_bus_cycles", n, 20);
    checkOutput("wait_no_err", errSeen, 0);
`endif
    applyStimulus(1'b1, 1'b1, 18'h3FFFF, 1'b0, 12'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    checkOutput("late_ack_ir", ir_o, 18'h3FFFF);
    checkOutput("late_ack_pc", pc_o, 12'h001);
    checkOutput("late_ack_valid", ir_valid_o, 1'b1);
    tick();

    // Reset mid bus cycle drops cyc/stb asynchronously
    applyStimulus(1'b1, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    checkOutput("rmid_cyc_before", inst_cyc_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rmid_cyc", inst_cyc_o, 1'b0);
    checkOutput("rmid_stb", inst_stb_o, 1'b0);
    checkOutput("rmid_pc", pc_o, 12'h010);
    checkOutput("rmid_ir", ir_o, 18'h0);
    applyStimulus(1'b0, 1'b0, 18'h0, 1'b0, 12'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
